// File: rtl/sdram_addr_manager.sv
// Circular-buffer write/read pointer manager for the SDRAM science store.
// Optional feature macro: WRAP_OVERWRITE_EN (write while full drops the oldest word).
module sdram_addr_manager #(
  parameter int COL_BITS = 9,
  parameter int ROW_BITS = 13,
  parameter int BA_BITS  = 2,
  parameter int AF_LEVEL = 16777000
) (
  input  logic                                   CLK_48MHZ,
  input  logic                                   RESET,
  input  logic                                   NEXT_WRITE,
  input  logic                                   NEXT_READ,
  input  logic                                   CLEAR_FLAGS,
  output logic [BA_BITS-1:0]                     BA_WRITE,
  output logic [ROW_BITS-1:0]                    ROW_WRITE,
  output logic [COL_BITS-1:0]                    COL_WRITE,
  output logic [BA_BITS-1:0]                     BA_READ,
  output logic [ROW_BITS-1:0]                    ROW_READ,
  output logic [COL_BITS-1:0]                    COL_READ,
  output logic [BA_BITS+ROW_BITS+COL_BITS:0]     WORD_COUNT,
  output logic                                   EMPTY,
  output logic                                   FULL,
  output logic                                   ALMOST_FULL,
  output logic                                   OVERFLOW,
  output logic                                   UNDERFLOW
);

  localparam int AW = BA_BITS + ROW_BITS + COL_BITS;
  localparam logic [AW:0] depth_cnt = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] af_cnt    = (AW+1)'(AF_LEVEL);

  logic          wr_prev, rd_prev;
  logic          wr_ev_q, rd_ev_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   word_count;
  logic          overflow, underflow;

  logic          is_full, is_empty;
  logic [AW-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [AW:0]   count_nxt;
  logic          ovf_set, udf_set;

  assign is_full  = (word_count == depth_cnt);
  assign is_empty = (word_count == '0);

  // Events are registered one cycle before they are resolved against the count.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = word_count;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    if (wr_ev_q && rd_ev_q) begin
      wr_ptr_nxt = wr_ptr + AW'(1);
      if (is_empty) begin
        count_nxt = word_count + (AW+1)'(1);
        udf_set   = 1'b1;
      end else begin
        rd_ptr_nxt = rd_ptr + AW'(1);
      end
    end else if (wr_ev_q) begin
      if (!is_full) begin
        wr_ptr_nxt = wr_ptr + AW'(1);
        count_nxt  = word_count + (AW+1)'(1);
      end else begin
        ovf_set = 1'b1;
`ifdef WRAP_OVERWRITE_EN
        wr_ptr_nxt = wr_ptr + AW'(1);
        rd_ptr_nxt = rd_ptr + AW'(1);
`endif
      end
    end else if (rd_ev_q) begin
      if (!is_empty) begin
        rd_ptr_nxt = rd_ptr + AW'(1);
        count_nxt  = word_count - (AW+1)'(1);
      end else begin
        udf_set = 1'b1;
      end
    end
  end

  // Edge-detect history resets high so a level already asserted at release is not counted.
  always_ff @(posedge CLK_48MHZ) begin
    if (!RESET) begin
      wr_prev    <= 1'b1;
      rd_prev    <= 1'b1;
      wr_ev_q    <= 1'b0;
      rd_ev_q    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wr_prev    <= NEXT_WRITE;
      rd_prev    <= NEXT_READ;
      wr_ev_q    <= NEXT_WRITE & ~wr_prev;
      rd_ev_q    <= NEXT_READ & ~rd_prev;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      word_count <= count_nxt;
      overflow   <= (overflow & ~CLEAR_FLAGS) | ovf_set;
      underflow  <= (underflow & ~CLEAR_FLAGS) | udf_set;
    end
  end

  assign BA_WRITE    = wr_ptr[AW-1 -: BA_BITS];
  assign ROW_WRITE   = wr_ptr[COL_BITS +: ROW_BITS];
  assign COL_WRITE   = wr_ptr[COL_BITS-1:0];
  assign BA_READ     = rd_ptr[AW-1 -: BA_BITS];
  assign ROW_READ    = rd_ptr[COL_BITS +: ROW_BITS];
  assign COL_READ    = rd_ptr[COL_BITS-1:0];
  assign WORD_COUNT  = word_count;
  assign EMPTY       = is_empty;
  assign FULL        = is_full;
  assign ALMOST_FULL = (word_count >= af_cnt);
  assign OVERFLOW    = overflow;
  assign UNDERFLOW   = underflow;

endmodule
